// File: rtl/irt_dep_table.sv
// In-flight register dependency table: circular FIFO of issued-but-unretired
// instructions, checked combinationally for RAW/WAR/WAW hazards against the incoming one.
module irt_dep_table #(
  parameter int IW     = 16,
  parameter int BS     = 16,
  parameter int RW     = 4,
  parameter int RD_LSB = 8,
  parameter int RS_LSB = 4,
  parameter int RT_LSB = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [IW-1:0]         instr_in,
  output logic                  in_ready,
  output logic [$clog2(BS)-1:0] in_tag,
  input  logic                  retire,
  output logic                  hazard_raw,
  output logic                  hazard_war,
  output logic                  hazard_waw,
  output logic [$clog2(BS):0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int             PW       = $clog2(BS);
  localparam logic [RW-1:0]  NONE     = '1;
  localparam logic [PW:0]    CNT_FULL = (PW+1)'(BS);

  logic [BS-1:0][RW-1:0] srd_q, srd_d;
  logic [BS-1:0][RW-1:0] srs_q, srs_d;
  logic [BS-1:0][RW-1:0] srt_q, srt_d;
  logic [BS-1:0]         vld_q, vld_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW:0]           cnt_q, cnt_d;

  logic [RW-1:0] f_rd, f_rs, f_rt;
  logic          raw_c, war_c, waw_c;
  logic          do_ins, do_ret;
  logic          unused_instr;

  assign f_rd = instr_in[RD_LSB +: RW];
  assign f_rs = instr_in[RS_LSB +: RW];
  assign f_rt = instr_in[RT_LSB +: RW];
  // Bits outside the three register fields (opcode etc.) are not needed here.
  assign unused_instr = ^instr_in;

  // An incoming NONE field never matches; a slot field can only equal a
  // non-NONE incoming field if it is itself non-NONE, so one test suffices.
  always_comb begin
    raw_c = 1'b0;
    war_c = 1'b0;
    waw_c = 1'b0;
    for (int i = 0; i < BS; i++) begin
      if (vld_q[i]) begin
        if (f_rs != NONE && f_rs == srd_q[i]) raw_c = 1'b1;
        if (f_rt != NONE && f_rt == srd_q[i]) raw_c = 1'b1;
        if (f_rd != NONE && (f_rd == srs_q[i] || f_rd == srt_q[i])) war_c = 1'b1;
        if (f_rd != NONE && f_rd == srd_q[i]) waw_c = 1'b1;
      end
    end
  end

  assign hazard_raw = raw_c;
  assign hazard_war = war_c;
  assign hazard_waw = waw_c;
  assign full       = (cnt_q == CNT_FULL);
  assign empty      = (cnt_q == '0);
  assign count      = cnt_q;
  assign in_tag     = wr_ptr_q;
  assign in_ready   = !full && !(raw_c || war_c || waw_c);
  assign do_ins     = in_valid && in_ready;
  assign do_ret     = retire && !empty;

  always_comb begin
    srd_d    = srd_q;
    srs_d    = srs_q;
    srt_d    = srt_q;
    vld_d    = vld_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      srd_d    = '1;
      srs_d    = '1;
      srt_d    = '1;
      vld_d    = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // Insert into a full table is impossible (in_ready low), so the
      // retire and insert slots never coincide.
      if (do_ret) begin
        srd_d[rd_ptr_q] = NONE;
        srs_d[rd_ptr_q] = NONE;
        srt_d[rd_ptr_q] = NONE;
        vld_d[rd_ptr_q] = 1'b0;
        rd_ptr_d        = rd_ptr_q + 1'b1;
      end
      if (do_ins) begin
        srd_d[wr_ptr_q] = f_rd;
        srs_d[wr_ptr_q] = f_rs;
        srt_d[wr_ptr_q] = f_rt;
        vld_d[wr_ptr_q] = 1'b1;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      case ({do_ins, do_ret})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      srd_q    <= '1;
      srs_q    <= '1;
      srt_q    <= '1;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      srd_q    <= srd_d;
      srs_q    <= srs_d;
      srt_q    <= srt_d;
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_irt_dep_table.sv
// Bench for irt_dep_table: queue-based reference table plus a scoreboard of
// expected occupancy, popped one cycle after each driven transaction.
module tb_irt_dep_table;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, retire;
  logic [15:0] instr_in;
  logic        in_ready, hazard_raw, hazard_war, hazard_waw, full, empty;
  logic [3:0]  in_tag;
  logic [4:0]  count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int   cnt;
    logic emp;
    logic ful;
  } exp_t;

  exp_t        sb[$];
  logic [11:0] mq[$];
  int          mtag = 0;

  irt_dep_table #(.IW(16), .BS(16), .RW(4), .RD_LSB(8), .RS_LSB(4), .RT_LSB(0)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .instr_in(instr_in),
    .in_ready(in_ready), .in_tag(in_tag), .retire(retire),
    .hazard_raw(hazard_raw), .hazard_war(hazard_war), .hazard_waw(hazard_waw),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] m_haz(input logic [15:0] ins);
    logic [3:0] rd, rs, rt;
    logic       raw, war, waw;
    rd = ins[11:8]; rs = ins[7:4]; rt = ins[3:0];
    raw = 1'b0; war = 1'b0; waw = 1'b0;
    foreach (mq[k]) begin
      if (rs != 4'hF && rs == mq[k][11:8]) raw = 1'b1;
      if (rt != 4'hF && rt == mq[k][11:8]) raw = 1'b1;
      if (rd != 4'hF && (rd == mq[k][7:4] || rd == mq[k][3:0])) war = 1'b1;
      if (rd != 4'hF && rd == mq[k][11:8]) waw = 1'b1;
    end
    return {raw, war, waw};
  endfunction

  // Advance one clock with the currently driven inputs, updating the reference
  // table and queuing the occupancy expected after the edge.
  task automatic cycle();
    logic acc;
    acc = in_valid && (mq.size() < 16) && (m_haz(instr_in) == 3'b000);
    if (flush) begin
      mq.delete();
      mtag = 0;
    end else begin
      if (retire && mq.size() > 0) void'(mq.pop_front());
      if (acc) begin
        mq.push_back(instr_in[11:0]);
        mtag = (mtag + 1) % 16;
      end
    end
    sb.push_back('{mq.size(), mq.size() == 0, mq.size() == 16});
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      vectors++;
      if (count !== 5'(e.cnt) || empty !== e.emp || full !== e.ful) begin
        miscompares++;
        $display("FAIL occupancy: count=%0d empty=%b full=%b, want count=%0d empty=%b full=%b",
                 count, empty, full, e.cnt, e.emp, e.ful);
      end
    end
  end

  task automatic test_reset();
    #1;
    vectors++;
    if ({count, empty, full, hazard_raw, hazard_war, hazard_waw, in_ready, in_tag} !==
        {5'd0, 1'b1, 1'b0, 3'b000, 1'b1, 4'd0}) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d empty=%b full=%b haz=%b%b%b rdy=%b tag=%0d",
               count, empty, full, hazard_raw, hazard_war, hazard_waw, in_ready, in_tag);
    end
  endtask

  task automatic test_hazards();
    instr_in = 16'h0312; in_valid = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b1 || in_tag !== 4'd0) begin
      miscompares++;
      $display("FAIL first_insert: rdy=%b tag=%0d, want rdy=1 tag=0", in_ready, in_tag);
    end
    cycle();
    in_valid = 1'b0;
    instr_in = 16'h0435; #1;
    vectors++;
    if (hazard_raw !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL raw: raw=%b rdy=%b, want raw=1 rdy=0", hazard_raw, in_ready);
    end
    instr_in = 16'h0145; #1;
    vectors++;
    if (hazard_war !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL war: war=%b rdy=%b, want war=1 rdy=0", hazard_war, in_ready);
    end
    instr_in = 16'h0356; #1;
    vectors++;
    if (hazard_waw !== 1'b1 || {hazard_raw, hazard_war} !== m_haz(instr_in)[2:1]) begin
      miscompares++;
      $display("FAIL waw: haz=%b%b%b, want %b", hazard_raw, hazard_war, hazard_waw, m_haz(instr_in));
    end
  endtask

  task automatic test_fill_wrap();
    flush = 1'b1; cycle(); flush = 1'b0;
    for (int i = 0; i < 16; i++) begin
      instr_in = {4'h0, 4'(i), 8'hFF}; in_valid = 1'b1; #1;
      vectors++;
      if (in_ready !== 1'b1 || in_tag !== 4'(i)) begin
        miscompares++;
        $display("FAIL fill_%0d: rdy=%b tag=%0d, want rdy=1 tag=%0d", i, in_ready, in_tag, i);
      end
      cycle();
    end
    in_valid = 1'b0;
    instr_in = 16'h0FFF; #1;
    vectors++;
    if ({hazard_raw, hazard_war, hazard_waw, in_ready} !== 4'b0000) begin
      miscompares++;
      $display("FAIL none_full: haz=%b%b%b rdy=%b, want 000 rdy=0",
               hazard_raw, hazard_war, hazard_waw, in_ready);
    end
    instr_in = 16'h0FF5; #1;
    vectors++;
    if ({hazard_raw, hazard_war, hazard_waw} !== 3'b100) begin
      miscompares++;
      $display("FAIL none_rt_match: haz=%b%b%b, want 100", hazard_raw, hazard_war, hazard_waw);
    end
    instr_in = 16'h0FFF; in_valid = 1'b1; retire = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL full_retire_rdy: rdy=%b, want 0", in_ready);
    end
    cycle();
    retire = 1'b0;
    instr_in = 16'h00FF; #1;
    vectors++;
    if (in_ready !== 1'b1 || in_tag !== 4'd0) begin
      miscompares++;
      $display("FAIL wrap_tag: rdy=%b tag=%0d, want rdy=1 tag=0", in_ready, in_tag);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    flush = 1'b1; cycle(); flush = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      instr_in = {4'h0, 4'(i), 8'hFF};
      cycle();
    end
    instr_in = 16'h06FF; retire = 1'b1; #1;
    vectors++;
    if (in_ready !== 1'b1 || in_tag !== 4'd5) begin
      miscompares++;
      $display("FAIL ins_ret_rdy: rdy=%b tag=%0d, want rdy=1 tag=5", in_ready, in_tag);
    end
    cycle();
    instr_in = 16'h0A2F; #1;
    vectors++;
    if (hazard_raw !== 1'b1 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL retiring_blocks: raw=%b rdy=%b, want raw=1 rdy=0", hazard_raw, in_ready);
    end
    cycle();
    retire = 1'b0; #1;
    vectors++;
    if (hazard_raw !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL retire_clears: raw=%b rdy=%b, want raw=0 rdy=1", hazard_raw, in_ready);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_flush_reset();
    flush = 1'b1; cycle(); flush = 1'b0;
    in_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      instr_in = {4'h0, 4'(i), 8'hFF};
      cycle();
    end
    instr_in = 16'h08FF; retire = 1'b1; flush = 1'b1;
    cycle();
    flush = 1'b0; retire = 1'b0; in_valid = 1'b0; #1;
    vectors++;
    if (in_tag !== 4'd0 || hazard_raw !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_tag: tag=%0d raw=%b, want tag=0 raw=0", in_tag, hazard_raw);
    end
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      instr_in = {4'h0, 4'(i), 8'hFF};
      cycle();
    end
    instr_in = 16'h09FF;
    #2; rst = 1'b1; #1;
    mq.delete(); mtag = 0;
    vectors++;
    if ({count, empty, full, in_tag} !== {5'd0, 1'b1, 1'b0, 4'd0}) begin
      miscompares++;
      $display("FAIL async_rst: count=%0d empty=%b full=%b tag=%0d, want 0 1 0 0",
               count, empty, full, in_tag);
    end
    #3; rst = 1'b0;
    instr_in = 16'h01FF; #1;
    vectors++;
    if (in_ready !== 1'b1 || in_tag !== 4'(mtag)) begin
      miscompares++;
      $display("FAIL post_rst: rdy=%b tag=%0d, want rdy=1 tag=%0d", in_ready, in_tag, mtag);
    end
    cycle();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; retire = 1'b0; instr_in = 16'h0000;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_hazards();
    test_fill_wrap();
    test_back_to_back();
    test_flush_reset();
    repeat (2) @(posedge clk);
    #3;
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
